// File: rtl/rpn_converter.sv
// Infix-to-postfix (shunting-yard) token converter with an internal operator stack,
// registered valid/ready output, and error detection with '='-based recovery.
module rpn_converter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [LVL_W-1:0]  stack_level
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] ST_READ  = 3'd0;
    localparam logic [2:0] ST_CMP   = 3'd1;
    localparam logic [2:0] ST_PAREN = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [7:0] CH_LP  = 8'd40;
    localparam logic [7:0] CH_RP  = 8'd41;
    localparam logic [7:0] CH_MUL = 8'd42;
    localparam logic [7:0] CH_ADD = 8'd43;
    localparam logic [7:0] CH_SUB = 8'd45;
    localparam logic [7:0] CH_DIV = 8'd47;
    localparam logic [7:0] CH_EQ  = 8'd61;

    localparam logic [1:0] EC_NONE     = 2'd0;
    localparam logic [1:0] EC_OVERFLOW = 2'd1;
    localparam logic [1:0] EC_UNM_RP   = 2'd2;
    localparam logic [1:0] EC_UNM_LP   = 2'd3;

    function automatic logic [1:0] prec(input logic [7:0] c);
        case (c)
            CH_MUL, CH_DIV: prec = 2'd2;
            CH_ADD, CH_SUB: prec = 2'd1;
            default:        prec = 2'd0;
        endcase
    endfunction

    logic [2:0]        state_r, state_nx_s;
    logic [DATA_W-1:0] tok_r, tok_nx_s;
    logic [DATA_W-1:0] stack_r [DEPTH];
    logic [LVL_W-1:0]  level_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              err_r, err_nx_s;
    logic [1:0]        err_code_r, err_code_nx_s;

    logic              slot_free_s, in_ready_s, accept_s;
    logic              empty_s, full_s;
    logic [IDX_W-1:0]  top_idx_s, push_idx_s;
    logic [DATA_W-1:0] top_s;
    logic              emit_s, push_s, pop_s, clear_s;
    logic [DATA_W-1:0] emit_data_s, push_data_s;

    assign slot_free_s = !out_valid_r || out_ready;
    assign in_ready_s  = ((state_r == ST_READ) || (state_r == ST_ERR)) && slot_free_s;
    assign accept_s    = in_valid && in_ready_s;
    assign empty_s     = (level_r == LVL_W'(0));
    assign full_s      = (level_r == LVL_W'(DEPTH));
    // top index wraps when empty; every use of top_s is guarded by empty_s
    assign top_idx_s   = IDX_W'(level_r - LVL_W'(1));
    assign push_idx_s  = IDX_W'(level_r);
    assign top_s       = stack_r[top_idx_s];

    // Next-state, stack-operation and emit decode for the shunting-yard FSM
    always_comb begin
        state_nx_s    = state_r;
        tok_nx_s      = tok_r;
        err_nx_s      = err_r;
        err_code_nx_s = err_code_r;
        emit_s        = 1'b0;
        emit_data_s   = {DATA_W{1'b0}};
        push_s        = 1'b0;
        push_data_s   = {DATA_W{1'b0}};
        pop_s         = 1'b0;
        clear_s       = 1'b0;
        case (state_r)
            ST_READ: begin
                if (accept_s) begin
                    err_nx_s      = 1'b0;
                    err_code_nx_s = EC_NONE;
                    case (in_data[7:0])
                        CH_LP: begin
                            if (full_s) begin
                                state_nx_s    = ST_ERR;
                                err_nx_s      = 1'b1;
                                err_code_nx_s = EC_OVERFLOW;
                            end else begin
                                push_s      = 1'b1;
                                push_data_s = in_data;
                            end
                        end
                        CH_MUL, CH_DIV, CH_ADD, CH_SUB: begin
                            tok_nx_s   = in_data;
                            state_nx_s = ST_CMP;
                        end
                        CH_RP:   state_nx_s = ST_PAREN;
                        CH_EQ:   state_nx_s = ST_FLUSH;
                        default: begin
                            emit_s      = 1'b1;
                            emit_data_s = in_data;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_READ;
                end
            end
            ST_CMP: begin
                if (!empty_s && (top_s[7:0] != CH_LP) && (prec(top_s[7:0]) >= prec(tok_r[7:0]))) begin
                    if (slot_free_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = top_s;
                        pop_s       = 1'b1;
                    end else begin
                        state_nx_s = ST_CMP;
                    end
                end else if (full_s) begin
                    state_nx_s    = ST_ERR;
                    err_nx_s      = 1'b1;
                    err_code_nx_s = EC_OVERFLOW;
                end else begin
                    push_s      = 1'b1;
                    push_data_s = tok_r;
                    state_nx_s  = ST_READ;
                end
            end
            ST_PAREN: begin
                if (empty_s) begin
                    state_nx_s    = ST_ERR;
                    err_nx_s      = 1'b1;
                    err_code_nx_s = EC_UNM_RP;
                end else if (top_s[7:0] == CH_LP) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_READ;
                end else if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_data_s = top_s;
                    pop_s       = 1'b1;
                end else begin
                    state_nx_s = ST_PAREN;
                end
            end
            ST_FLUSH: begin
                if (empty_s) begin
                    if (slot_free_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = DATA_W'(CH_EQ);
                        state_nx_s  = ST_READ;
                    end else begin
                        state_nx_s = ST_FLUSH;
                    end
                end else if (top_s[7:0] == CH_LP) begin
                    state_nx_s    = ST_ERR;
                    err_nx_s      = 1'b1;
                    err_code_nx_s = EC_UNM_LP;
                end else if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_data_s = top_s;
                    pop_s       = 1'b1;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_ERR: begin
                // err stays set here; it clears on the first token accepted back in READ
                if (accept_s && (in_data[7:0] == CH_EQ)) begin
                    clear_s    = 1'b1;
                    state_nx_s = ST_READ;
                end else begin
                    state_nx_s = ST_ERR;
                end
            end
            default: state_nx_s = ST_READ;
        endcase
    end

    // FSM, latched operator and error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_READ;
            tok_r      <= {DATA_W{1'b0}};
            err_r      <= 1'b0;
            err_code_r <= EC_NONE;
        end else begin
            state_r    <= state_nx_s;
            tok_r      <= tok_nx_s;
            err_r      <= err_nx_s;
            err_code_r <= err_code_nx_s;
        end
    end

    // Operator stack storage and level counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r <= LVL_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clear_s) begin
            level_r <= LVL_W'(0);
        end else if (push_s) begin
            stack_r[push_idx_s] <= push_data_s;
            level_r             <= level_r + LVL_W'(1);
        end else if (pop_s) begin
            level_r <= level_r - LVL_W'(1);
        end else begin
            level_r <= level_r;
        end
    end

    // Single-entry output slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= emit_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign err         = err_r;
    assign err_code    = err_code_r;
    assign stack_level = level_r;

endmodule

// File: doc/rpn_converter.md
# rpn_converter

Parametrised infix-to-postfix (shunting-yard) converter for the polish-notation datapath. It accepts one ASCII token per handshake and holds operators on an internal stack of configurable depth. It emits the postfix token stream through a registered valid/ready output. It supports parentheses, left-associative precedence, '=' expression termination, and error detection with recovery.

## Interface
- DATA_W, 8, token width in bits; codes are compared on the low 8 bits, upper bits must be zero.
- DEPTH, 16, operator stack entries, minimum 2.
- LVL_W, $clog2(DEPTH+1), width of stack_level.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input token valid.
- in_data  in  DATA_W  input token.
- in_ready  out  1  block can accept a token this cycle.
- out_valid  out  1  out_data holds a postfix token.
- out_data  out  DATA_W  postfix token.
- out_ready  in  1  downstream accepts out_data.
- err  out  1  error flag, held until the next expression starts.
- err_code  out  2  0 none, 1 stack overflow, 2 unmatched ')', 3 unmatched '('.
- stack_level  out  LVL_W  current number of stack entries.

## Operation
- Token classes:
  - '*' (42) and '/' (47): precedence 2.
  - '+' (43) and '-' (45): precedence 1.
  - '(' (40), ')' (41), and '=' (61): control tokens.
  - Any other value is an operand.
- Output slot: a single register. slot_free = !out_valid || out_ready. An "emit" loads out_data and sets out_valid. It is permitted only when slot_free. out_valid clears when out_ready is high and no new emit happens.
- Handshake: a transfer occurs on a cycle with valid && ready high. in_ready = (state==READ || state==ERR) && slot_free.
- READ state:
  - Operand: emit it and stay in READ.
  - '(': push it. If the stack is full, go to ERR with code 1.
  - Operator: latch it in tok and go to CMP.
  - ')': go to PAREN.
  - '=': go to FLUSH.
- CMP state:
  - If the stack is non-empty, top != '(' and prec(top) >= prec(tok): emit top, pop, and stay in CMP.
  - Otherwise push tok and go to READ. If the stack is full, go to ERR with code 1.
- PAREN state:
  - Empty stack: go to ERR with code 2.
  - top == '(': pop and discard it, go to READ. Nothing is emitted.
  - Otherwise: emit top, pop, and stay in PAREN.
- FLUSH state:
  - Empty stack: emit '=' and go to READ.
  - top == '(': go to ERR with code 3.
  - Otherwise: emit top, pop, and stay in FLUSH.
- ERR state:
  - err = 1 and err_code is held.
  - Tokens are accepted and discarded.
  - Accepting '=' clears the stack (stack_level = 0) and returns to READ. No '=' is emitted.
  - err and err_code clear on the first token accepted in READ afterwards.
- Any emitting step stalls with no state change while !slot_free.
- There is no new input acceptance outside READ and ERR.

## Timing
- Reset values:
  - Outputs: out_valid 0, out_data 0, err 0, err_code 0, stack_level 0.
  - state = READ, so in_ready = 1 immediately after reset deassertion.
- Reset asserted mid-expression discards the stack and any pending out_data in the same cycle (asynchronous clear).
- Operand latency: accepted at edge N, out_valid = 1 after edge N.
- Operator with k higher-or-equal operators on the stack:
  - k cycles in CMP (one pop and emit per cycle), plus one push cycle.
  - in_ready is 0 during those cycles.
- '=' with k stacked operators: k+1 FLUSH cycles, then in_ready returns to 1.
- With out_ready held high, the output sustains one token per cycle.
- A push when stack_level == DEPTH is never performed. stack_level saturates at DEPTH.
- Simultaneous pop and output handshake in one cycle is legal. The new top is used in the next cycle.

## Test plan
- Precedence: "a+b*c=" with out_ready = 1 -> output "abc*+=" (97,98,99,42,43,61); err stays 0.
- Parentheses and associativity:
  - "(a+b)*c=" -> "ab+c*=".
  - "a-b-c=" -> "ab-c-=" (left-associative).
  - stack_level returns to 0 after '='.
- Backpressure: "a*b+c=" with out_ready = 0 for 5 cycles during FLUSH -> no token lost or duplicated, out_data stable while stalled, in_ready = 0; final output "ab*c+=".
- Unmatched: ")a=" -> err = 1, err_code = 2. Then "a+b=" -> "ab+=", and err clears on accepting 'a'. "(a=" -> err_code = 3.
- Overflow: DEPTH = 4, "(((((a=" -> err_code = 1 on the fifth '('; stack cleared after '='; the next "x/y=" yields "xy/=".
- Reset mid-expression: assert reset during CMP with 3 entries stacked -> stack_level = 0, out_valid = 0, in_ready = 1 after release.
